// File: rtl/audio_rx_pkg.sv
// Shared definitions for the I2S ADC receive path: default widths and capture FSM states.
package audio_rx_pkg;

    localparam int unsigned DATA_W_DEFAULT      = 16;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level, with rise and change strobes
// derived from the synchronized value (one clk cycle wide).
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic change
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= (chain << 1) | STAGES'(din);
            prev  <= chain[STAGES-1];
        end
    end

    assign sync   = chain[STAGES-1];
    assign rise   = sync & ~prev;
    assign change = sync ^ prev;

endmodule

// File: rtl/audio_adc_deserializer.sv
// I2S codec ADC receiver: captures frame-aligned left/right words and presents them
// as stereo pairs through a one-deep output register with sticky overrun.
module audio_adc_deserializer
    import audio_rx_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              adc_bclk,
    input  logic              adc_lrck,
    input  logic              adc_dat,
    output logic [DATA_W-1:0] sample_left,
    output logic [DATA_W-1:0] sample_right,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic bclk_sync, bclk_rise, bclk_change;
    logic lrck_s, lrck_rise, lrck_change;
    logic [SYNC_STAGES-1:0] dat_chain;
    logic dat_s;
    logic unused;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk     (clk_clk),
        .reset_n (reset_reset_n),
        .din     (adc_bclk),
        .sync    (bclk_sync),
        .rise    (bclk_rise),
        .change  (bclk_change)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_lrck_sync (
        .clk     (clk_clk),
        .reset_n (reset_reset_n),
        .din     (adc_lrck),
        .sync    (lrck_s),
        .rise    (lrck_rise),
        .change  (lrck_change)
    );

    assign unused = ^{bclk_sync, bclk_change, lrck_rise, lrck_change};

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            dat_chain <= '0;
        end else begin
            dat_chain <= (dat_chain << 1) | SYNC_STAGES'(adc_dat);
        end
    end

    assign dat_s = dat_chain[SYNC_STAGES-1];

    rx_state_t         state, state_next;
    logic              lrck_prev;
    logic              chan_start;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shift_next;
    logic [CNT_W-1:0]  pad_shift;
    logic              chan;
    logic              last_bit;
    logic              start_word, shift_bit, finish_full, finish_short;
    logic              word_done, word_right;
    logic [DATA_W-1:0] word_data;
    logic [DATA_W-1:0] left_stage;
    logic              commit, accept;

    // A channel starts on the first bclk rise that sees a new lrck level;
    // that rise is the I2S delay slot, so the MSB arrives on the following one.
    assign chan_start = bclk_rise && (lrck_s != lrck_prev);
    assign last_bit   = (cnt == CNT_W'(DATA_W - 1));
    assign shift_next = {shreg[DATA_W-2:0], dat_s};
    assign pad_shift  = CNT_W'(DATA_W) - cnt;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (chan_start && !lrck_s) state_next = SKIP;
            end
            SKIP: begin
                if (chan_start)     state_next = SKIP;
                else if (bclk_rise) state_next = last_bit ? HOLD : SHIFT;
            end
            SHIFT: begin
                if (chan_start)                 state_next = SKIP;
                else if (bclk_rise && last_bit) state_next = HOLD;
            end
            HOLD: begin
                if (chan_start) state_next = SKIP;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start_word   = 1'b0;
        shift_bit    = 1'b0;
        finish_short = 1'b0;
        case (state)
            IDLE:  start_word = chan_start && !lrck_s;
            SKIP: begin
                start_word = chan_start;
                shift_bit  = bclk_rise && !chan_start;
            end
            SHIFT: begin
                start_word   = chan_start;
                finish_short = chan_start;
                shift_bit    = bclk_rise && !chan_start;
            end
            HOLD:  start_word = chan_start;
            default: start_word = 1'b0;
        endcase
        finish_full = shift_bit && last_bit;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            lrck_prev  <= 1'b0;
            cnt        <= '0;
            shreg      <= '0;
            chan       <= 1'b0;
            word_done  <= 1'b0;
            word_right <= 1'b0;
            word_data  <= '0;
            left_stage <= '0;
        end else begin
            if (bclk_rise) lrck_prev <= lrck_s;

            word_done <= finish_full || finish_short;
            if (finish_full || finish_short) begin
                word_right <= chan;
                // A short word is left-justified so the missing LSBs read as zero.
                word_data  <= finish_full ? shift_next : (shreg << pad_shift);
            end

            if (start_word) begin
                shreg <= '0;
                cnt   <= '0;
                chan  <= lrck_s;
            end else if (shift_bit) begin
                shreg <= shift_next;
                cnt   <= cnt + CNT_W'(1);
            end

            if (word_done && !word_right) left_stage <= word_data;
        end
    end

    assign commit = word_done && word_right;
    assign accept = sample_valid && sample_ready;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (commit && (!sample_valid || sample_ready)) begin
                sample_left  <= left_stage;
                sample_right <= word_data;
                sample_valid <= 1'b1;
            end else if (accept) begin
                sample_valid <= 1'b0;
            end

            if (commit && sample_valid && !sample_ready) overrun <= 1'b1;
            else if (overrun_clr)                        overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// Directed bench for the I2S ADC receiver: drives I2S frames from a free-running
// bit clock and checks captured pairs, handshake, overrun and reset behaviour.
module tb_audio_adc_deserializer;

    localparam int HALF_BCLK = 163;

    logic        clk_clk       = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        adc_bclk      = 1'b0;
    logic        adc_lrck      = 1'b1;
    logic        adc_dat       = 1'b0;
    logic        sample_ready  = 1'b0;
    logic        overrun_clr   = 1'b0;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        sample_valid;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    int          acc_count = 0;
    int          valid_low = 0;
    logic [15:0] acc_left  = '0;
    logic [15:0] acc_right = '0;

    audio_adc_deserializer #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .adc_bclk      (adc_bclk),
        .adc_lrck      (adc_lrck),
        .adc_dat       (adc_dat),
        .sample_left   (sample_left),
        .sample_right  (sample_right),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    always #10 clk_clk = ~clk_clk;

    always @(posedge clk_clk) begin
        if (reset_reset_n && sample_valid && sample_ready) begin
            acc_count <= acc_count + 1;
            acc_left  <= sample_left;
            acc_right <= sample_right;
        end
        if (reset_reset_n && !sample_valid) valid_low <= valid_low + 1;
    end

    // Slot 0 is the I2S delay slot, slots 1..16 carry the word MSB first.
    // On slot 'align' the rising bclk is placed on a clk falling edge and
    // sample_ready is pulsed for the clk edge on which that LSB pair commits.
    task automatic send_slots(input logic ch, input logic [15:0] w,
                              input int first, input int last, input int align);
        for (int i = first; i <= last; i++) begin
            adc_bclk = 1'b0;
            adc_lrck = ch;
            adc_dat  = (i >= 1 && i <= 16) ? w[16-i] : 1'b0;
            #HALF_BCLK;
            if (i == align) begin
                @(negedge clk_clk);
                fork
                    begin
                        repeat (3) @(negedge clk_clk);
                        sample_ready = 1'b1;
                        @(negedge clk_clk);
                        sample_ready = 1'b0;
                    end
                join_none
            end
            adc_bclk = 1'b1;
            #HALF_BCLK;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slots(1'b0, l, 0, 31, -1);
        send_slots(1'b1, r, 0, 31, -1);
    endtask

    task automatic test_reset;
        reset_reset_n = 1'b0;
        repeat (5) @(negedge clk_clk);
        checks++; if (sample_left !== 16'h0000) begin failures++; $display("FAIL reset_left: got %h expected 0000", sample_left); end
        checks++; if (sample_right !== 16'h0000) begin failures++; $display("FAIL reset_right: got %h expected 0000", sample_right); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        reset_reset_n = 1'b1;
    endtask

    task automatic test_basic;
        int a0;
        sample_ready = 1'b1;
        send_slots(1'b1, 16'h0000, 0, 3, -1);
        a0 = acc_count;
        send_frame(16'h1234, 16'hABCD);
        send_slots(1'b1, 16'h0000, 0, 1, -1);
        @(negedge clk_clk);
        checks++; if (acc_count - a0 !== 1) begin failures++; $display("FAIL basic_pulses: got %0d expected 1", acc_count - a0); end
        checks++; if (acc_left !== 16'h1234) begin failures++; $display("FAIL basic_left: got %h expected 1234", acc_left); end
        checks++; if (acc_right !== 16'hABCD) begin failures++; $display("FAIL basic_right: got %h expected abcd", acc_right); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_clear: got %b expected 0", sample_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_overrun;
        int a0;
        sample_ready = 1'b0;
        send_frame(16'h1111, 16'h2222);
        send_frame(16'h3333, 16'h4444);
        send_slots(1'b1, 16'h0000, 0, 1, -1);
        @(negedge clk_clk);
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_held: got %b expected 1", sample_valid); end
        checks++; if (sample_left !== 16'h1111) begin failures++; $display("FAIL ovr_left_held: got %h expected 1111", sample_left); end
        checks++; if (sample_right !== 16'h2222) begin failures++; $display("FAIL ovr_right_held: got %h expected 2222", sample_right); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        a0 = acc_count;
        sample_ready = 1'b1;
        repeat (2) @(negedge clk_clk);
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL ovr_accept_valid: got %b expected 0", sample_valid); end
        checks++; if (acc_count - a0 !== 1 || acc_left !== 16'h1111 || acc_right !== 16'h2222) begin
            failures++; $display("FAIL ovr_accept_pair: got n=%0d %h/%h expected n=1 1111/2222", acc_count - a0, acc_left, acc_right);
        end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        overrun_clr = 1'b1;
        @(negedge clk_clk);
        overrun_clr = 1'b0;
        @(negedge clk_clk);
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_short_word;
        int a0;
        sample_ready = 1'b1;
        a0 = acc_count;
        send_slots(1'b0, 16'hA5FF, 0, 8, -1);
        send_slots(1'b1, 16'h5A3C, 0, 31, -1);
        send_slots(1'b1, 16'h0000, 0, 1, -1);
        @(negedge clk_clk);
        checks++; if (acc_count - a0 !== 1) begin failures++; $display("FAIL short_pulses: got %0d expected 1", acc_count - a0); end
        checks++; if (acc_left !== 16'hA500) begin failures++; $display("FAIL short_left: got %h expected a500", acc_left); end
        checks++; if (acc_right !== 16'h5A3C) begin failures++; $display("FAIL short_right: got %h expected 5a3c", acc_right); end
    endtask

    task automatic test_back_to_back;
        int a0;
        int v0;
        sample_ready = 1'b0;
        send_frame(16'hC001, 16'hC002);
        @(negedge clk_clk);
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid: got %b expected 1", sample_valid); end
        a0 = acc_count;
        v0 = valid_low;
        send_slots(1'b0, 16'hD001, 0, 31, -1);
        send_slots(1'b1, 16'hD002, 0, 31, 16);
        send_slots(1'b1, 16'h0000, 0, 1, -1);
        @(negedge clk_clk);
        checks++; if (acc_count - a0 !== 1 || acc_left !== 16'hC001 || acc_right !== 16'hC002) begin
            failures++; $display("FAIL b2b_accept_old: got n=%0d %h/%h expected n=1 c001/c002", acc_count - a0, acc_left, acc_right);
        end
        checks++; if (valid_low - v0 !== 0) begin failures++; $display("FAIL b2b_valid_gap: got %0d low cycles expected 0", valid_low - v0); end
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid: got %b expected 1", sample_valid); end
        checks++; if (sample_left !== 16'hD001 || sample_right !== 16'hD002) begin
            failures++; $display("FAIL b2b_new_pair: got %h/%h expected d001/d002", sample_left, sample_right);
        end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_reset_mid_right;
        int a0;
        @(negedge clk_clk);
        reset_reset_n = 1'b0;
        sample_ready  = 1'b1;
        send_slots(1'b0, 16'h5555, 0, 31, -1);
        send_slots(1'b1, 16'h6666, 0, 5, -1);
        reset_reset_n = 1'b1;
        a0 = acc_count;
        send_slots(1'b1, 16'h6666, 6, 31, -1);
        @(negedge clk_clk);
        checks++; if (acc_count - a0 !== 0 || sample_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_no_valid: got n=%0d valid=%b expected n=0 valid=0", acc_count - a0, sample_valid);
        end
        send_frame(16'h1357, 16'h2468);
        send_slots(1'b1, 16'h0000, 0, 1, -1);
        @(negedge clk_clk);
        checks++; if (acc_count - a0 !== 1) begin failures++; $display("FAIL rstmid_pulses: got %0d expected 1", acc_count - a0); end
        checks++; if (acc_left !== 16'h1357 || acc_right !== 16'h2468) begin
            failures++; $display("FAIL rstmid_pair: got %h/%h expected 1357/2468", acc_left, acc_right);
        end
    endtask

    task automatic test_reset_pulse;
        int a0;
        sample_ready = 1'b0;
        send_frame(16'h7777, 16'h8888);
        send_frame(16'h9999, 16'hAAAA);
        send_slots(1'b0, 16'hBBBB, 0, 31, -1);
        send_slots(1'b1, 16'hCCCC, 0, 7, -1);
        @(negedge clk_clk);
        checks++; if (sample_valid !== 1'b1 || overrun !== 1'b1) begin
            failures++; $display("FAIL rstpulse_pre: got valid=%b overrun=%b expected 1/1", sample_valid, overrun);
        end
        reset_reset_n = 1'b0;
        repeat (3) @(negedge clk_clk);
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL rstpulse_valid: got %b expected 0", sample_valid); end
        checks++; if (sample_left !== 16'h0000 || sample_right !== 16'h0000) begin
            failures++; $display("FAIL rstpulse_data: got %h/%h expected 0000/0000", sample_left, sample_right);
        end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rstpulse_overrun: got %b expected 0", overrun); end
        reset_reset_n = 1'b1;
        send_slots(1'b1, 16'hCCCC, 8, 31, -1);
        sample_ready = 1'b1;
        a0 = acc_count;
        send_frame(16'h0F0F, 16'hF0F0);
        send_slots(1'b1, 16'h0000, 0, 1, -1);
        @(negedge clk_clk);
        checks++; if (acc_count - a0 !== 1) begin failures++; $display("FAIL rstpulse_pulses: got %0d expected 1", acc_count - a0); end
        checks++; if (acc_left !== 16'h0F0F || acc_right !== 16'hF0F0) begin
            failures++; $display("FAIL rstpulse_pair: got %h/%h expected 0f0f/f0f0", acc_left, acc_right);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_short_word();
        test_back_to_back();
        test_reset_mid_right();
        test_reset_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
